// File: rtl/decrementer_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decrementer_arbiter_ctrl
// Purpose  : Iterative decrement sequencer. Two requesters share a single
//            4-bit sign-magnitude decrementer. A granted command loads one
//            operand and runs Steps+1 decrements, one per clock. It stops
//            early when a step underflows. The result is returned on a
//            registered valid/ready response channel.
// Config   : `define DEC_CTRL_ROUND_ROBIN_EN -> round-robin arbitration
//                                               (Last_Grant register)
//            undefined                       -> fixed priority, port 0 wins
// Ports    : clk, rst_n (synchronous, active-low)
//            ReqN_Valid/ReqN_Ready   command handshake, N = 0,1
//            ReqN_A/ReqN_B           4-bit operands
//            ReqN_Sel                0 = decrement A, 1 = decrement B
//            ReqN_Steps              decrement count minus one
//            Rsp_Valid/Rsp_Ready     response handshake
//            Rsp_Out/Rsp_Neg/Rsp_Id  result magnitude, sign, requester index
//            Busy                    high while RUN or DONE
// Revision : 1.0 - initial release
// ============================================================================
module decrementer_arbiter_ctrl #(
   parameter int STEP_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Req0_Valid,
   output logic              Req0_Ready,
   input  logic [3:0]        Req0_A,
   input  logic [3:0]        Req0_B,
   input  logic              Req0_Sel,
   input  logic [STEP_W-1:0] Req0_Steps,
   input  logic              Req1_Valid,
   output logic              Req1_Ready,
   input  logic [3:0]        Req1_A,
   input  logic [3:0]        Req1_B,
   input  logic              Req1_Sel,
   input  logic [STEP_W-1:0] Req1_Steps,
   output logic              Rsp_Valid,
   input  logic              Rsp_Ready,
   output logic [3:0]        Rsp_Out,
   output logic              Rsp_Neg,
   output logic              Rsp_Id,
   output logic              Busy
);

   // One extra bit so that Steps+1 fits without overflow.
   localparam int REM_W = STEP_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [3:0]       w;
   logic [REM_W-1:0] remaining;
   logic             id;
   logic             grant;
   logic             any_valid;
   logic             accept;
   logic [3:0]       dec_out;
   logic             dec_neg;
   logic             finish;

   // Single-step decrement. Zero does not wrap to 1111: it becomes
   // magnitude 1 with the negative flag set.
   always_comb begin
      dec_neg = (w == 4'b0000);
      dec_out = dec_neg ? 4'b0001 : (w - 4'b0001);
   end

   // Arbitration. grant is the winning port index. It only matters while at
   // least one requester is valid.
`ifdef DEC_CTRL_ROUND_ROBIN_EN
   logic last_grant;

   always_comb begin
      grant = Req1_Valid;
      if (Req0_Valid && Req1_Valid)
         grant = ~last_grant;
   end

   // Reset to 1 so that port 0 wins the first contested grant.
   always_ff @(posedge clk) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= grant;
   end
`else
   always_comb begin
      grant = ~Req0_Valid;
   end
`endif

   assign any_valid = Req0_Valid | Req1_Valid;
   assign accept    = (Req0_Valid & Req0_Ready) | (Req1_Valid & Req1_Ready);
   assign finish    = (remaining == REM_W'(1)) | dec_neg;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // FSM next state and outputs. Ready is gated by rst_n so that it is low
   // combinationally whenever reset is asserted.
   always_comb begin
      next_state = state;
      Req0_Ready = 1'b0;
      Req1_Ready = 1'b0;
      Rsp_Valid  = 1'b0;
      Busy       = 1'b1;
      case (state)
         IDLE: begin
            Busy       = 1'b0;
            Req0_Ready = rst_n & any_valid & ~grant;
            Req1_Ready = rst_n & any_valid & grant;
            if (accept)
               next_state = RUN;
         end
         RUN: begin
            if (finish)
               next_state = DONE;
         end
         DONE: begin
            Rsp_Valid = 1'b1;
            if (Rsp_Ready)
               next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath: the operand is loaded on acceptance and iterated in RUN. The
   // response fields change only on the transition into DONE, so they stay
   // stable for as long as the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w         <= 4'b0000;
         remaining <= '0;
         id        <= 1'b0;
         Rsp_Out   <= 4'b0000;
         Rsp_Neg   <= 1'b0;
         Rsp_Id    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (grant) begin
                     w         <= Req1_Sel ? Req1_B : Req1_A;
                     remaining <= REM_W'(Req1_Steps) + REM_W'(1);
                  end else begin
                     w         <= Req0_Sel ? Req0_B : Req0_A;
                     remaining <= REM_W'(Req0_Steps) + REM_W'(1);
                  end
                  id <= grant;
               end
            end
            RUN: begin
               w         <= dec_out;
               remaining <= remaining - REM_W'(1);
               if (finish) begin
                  Rsp_Out <= dec_out;
                  Rsp_Neg <= dec_neg;
                  Rsp_Id  <= id;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decrementer_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decrementer_arbiter_ctrl
// Purpose  : Self-checking bench for decrementer_arbiter_ctrl. Directed
//            commands record their hand-computed results in per-port tables.
//            An acceptance watcher pushes the entry for the accepted port
//            into a scoreboard queue. A response monitor pops the queue and
//            compares each response, including its latency and its
//            stability during stalls.
// Config   : honours DEC_CTRL_ROUND_ROBIN_EN for the expected grant order
// Revision : 1.0 - initial release
// ============================================================================
module tb_decrementer_arbiter_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       Req0_Valid, Req0_Ready, Req0_Sel;
   logic [3:0] Req0_A, Req0_B;
   logic [1:0] Req0_Steps;
   logic       Req1_Valid, Req1_Ready, Req1_Sel;
   logic [3:0] Req1_A, Req1_B;
   logic [1:0] Req1_Steps;
   logic       Rsp_Valid, Rsp_Ready, Rsp_Neg, Rsp_Id, Busy;
   logic [3:0] Rsp_Out;

   decrementer_arbiter_ctrl #(.STEP_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_A(Req0_A),
      .Req0_B(Req0_B), .Req0_Sel(Req0_Sel), .Req0_Steps(Req0_Steps),
      .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_A(Req1_A),
      .Req1_B(Req1_B), .Req1_Sel(Req1_Sel), .Req1_Steps(Req1_Steps),
      .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Out(Rsp_Out),
      .Rsp_Neg(Rsp_Neg), .Rsp_Id(Rsp_Id), .Busy(Busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [3:0] out;
      logic       neg;
      int         k;
      int         acc;
   } exp_t;

   exp_t       sbq[$];
   int         glog[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   bit         push_en = 1'b1;
   logic [3:0] exp_out [2];
   logic       exp_neg [2];
   int         exp_k   [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Edge counter: cyc equals N after the N-th rising edge.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Acceptance watcher: a Valid&Ready seen here is taken at the next edge.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && push_en) begin
         for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? (Req0_Valid && Req0_Ready) : (Req1_Valid && Req1_Ready)) begin
               e.id  = p;
               e.out = exp_out[p];
               e.neg = exp_neg[p];
               e.k   = exp_k[p];
               e.acc = cyc + 1;
               sbq.push_back(e);
               glog.push_back(p);
            end
         end
      end
   end

   // Response monitor.
   initial begin
      exp_t cur;
      bit   seen;
      seen = 1'b0;
      cur  = '{0, 4'h0, 1'b0, 0, 0};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (Rsp_Valid) begin
            if (!seen) begin
               seen = 1'b1;
               if (sbq.size() == 0) begin
                  check("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  cur = sbq.pop_front();
                  check("rsp_out", 32'(Rsp_Out), 32'(cur.out));
                  check("rsp_neg", 32'(Rsp_Neg), 32'(cur.neg));
                  check("rsp_id", 32'(Rsp_Id), 32'(cur.id));
                  check("latency", 32'(cyc - cur.acc), 32'(cur.k));
               end
            end else begin
               check("hold_fields", {27'd0, Rsp_Out, Rsp_Neg, Rsp_Id},
                     {27'd0, cur.out, cur.neg, cur.id[0]});
               check("stall_ready_busy", {29'd0, Req0_Ready, Req1_Ready, Busy}, 32'b001);
            end
            if (Rsp_Ready)
               seen = 1'b0;
         end
      end
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drive(input int p, input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic sel, input logic [1:0] st);
      if (p == 0) begin
         Req0_Valid = v; Req0_A = a; Req0_B = b; Req0_Sel = sel; Req0_Steps = st;
      end else begin
         Req1_Valid = v; Req1_A = a; Req1_B = b; Req1_Sel = sel; Req1_Steps = st;
      end
   endtask

   task automatic set_exp(input int p, input logic [3:0] eo, input logic en, input int ek);
      exp_out[p] = eo;
      exp_neg[p] = en;
      exp_k[p]   = ek;
   endtask

   // Issue one command and return one delay after its acceptance edge, with
   // the operands scrambled to show they are no longer sampled.
   task automatic send(input int p, input logic [3:0] a, input logic [3:0] b, input logic sel,
                       input logic [1:0] st, input logic [3:0] eo, input logic en, input int ek);
      bit ok;
      set_exp(p, eo, en, ek);
      @(posedge clk); #1;
      drive(p, 1'b1, a, b, sel, st);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if ((p == 0) ? Req0_Ready : Req1_Ready)
            ok = 1'b1;
      end
      check("accept_timeout", 32'(ok), 32'd1);
      @(posedge clk); #1;
      drive(p, 1'b0, ~a, ~b, ~sel, ~st);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (sbq.size() == 0 && !Busy && !Rsp_Valid)
            ok = 1'b1;
      end
      check("idle_timeout", 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int exp_g[4];
      bit ok;
      rst_n     = 1'b0;
      Rsp_Ready = 1'b1;
      drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
      drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
      set_exp(0, 4'h0, 1'b0, 0);
      set_exp(1, 4'h0, 1'b0, 0);
      apply_reset();
      @(negedge clk);
      check("reset_state", {23'd0, Rsp_Valid, Rsp_Out, Rsp_Neg, Rsp_Id, Busy, Req0_Ready, Req1_Ready},
            32'd0);

      // Directed commands: port, A, B, Sel, Steps, expected Out, Neg, k.
      send(0, 4'b0101, 4'b1010, 1'b0, 2'd2, 4'b0010, 1'b0, 3); wait_idle();
      send(1, 4'b1111, 4'b0001, 1'b1, 2'd3, 4'b0001, 1'b1, 2); wait_idle();
      send(0, 4'b0000, 4'b0111, 1'b0, 2'd0, 4'b0001, 1'b1, 1); wait_idle();
      send(1, 4'b0000, 4'b1111, 1'b1, 2'd3, 4'b1011, 1'b0, 4); wait_idle();
      send(0, 4'b1001, 4'b0011, 1'b1, 2'd1, 4'b0001, 1'b0, 2); wait_idle();
      send(0, 4'b0010, 4'b1100, 1'b0, 2'd3, 4'b0001, 1'b1, 3); wait_idle();

      // Stall in DONE for five cycles while port 0 is requesting.
      Rsp_Ready = 1'b0;
      send(1, 4'b0000, 4'b0110, 1'b1, 2'd0, 4'b0101, 1'b0, 1);
      drive(0, 1'b1, 4'b0111, 4'b0000, 1'b0, 2'd0);
      repeat (6) @(posedge clk);
      #1;
      Rsp_Ready = 1'b1;
      drive(0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
      wait_idle();

      // Both requesters continuously valid after reset.
      apply_reset();
      glog.delete();
      set_exp(0, 4'b0010, 1'b0, 3);
      set_exp(1, 4'b1011, 1'b0, 4);
      drive(0, 1'b1, 4'b0101, 4'b0000, 1'b0, 2'd2);
      drive(1, 1'b1, 4'b0000, 4'b1111, 1'b1, 2'd3);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (glog.size() >= 4)
            ok = 1'b1;
      end
      check("grant_timeout", 32'(ok), 32'd1);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
      drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
      wait_idle();
`ifdef DEC_CTRL_ROUND_ROBIN_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 4; i++)
         if (i < glog.size())
            check($sformatf("grant_order_%0d", i), 32'(glog[i]), 32'(exp_g[i]));

      // Reset during RUN of a Steps=3 command discards it.
      push_en = 1'b0;
      send(0, 4'b1111, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 0);
      rst_n   = 1'b0;
      push_en = 1'b1;
      set_exp(0, 4'b0001, 1'b0, 2);
      set_exp(1, 4'b0011, 1'b0, 1);
      drive(0, 1'b1, 4'b0011, 4'b0000, 1'b0, 2'd1);
      drive(1, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd0);
      @(negedge clk);
      check("ready_in_reset", {30'd0, Req0_Ready, Req1_Ready}, 32'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_idle", {30'd0, Rsp_Valid, Busy}, 32'b00);
      check("post_reset_grant", {30'd0, Req0_Ready, Req1_Ready}, 32'b10);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
      drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
